// File: rtl/imem_loader.sv
// imem_loader: boot loader that turns a byte stream into little-endian 32-bit instruction-memory writes, then releases the CPU.
// Latency: write strobe one cycle after the 4th byte of a word is accepted; cpu_run one cycle after the final write.
// Backpressure: in_ready is high only while header/data/checksum bytes are expected; low in reset and in the terminal RUN/ERR states.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailing checksum byte
// (XOR of all data bytes) before the CPU is released; a mismatch ends in ERR.
//
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   in_valid/in_ready    byte-stream handshake, in_byte carries the byte
//   we/waddr/wdata       registered instruction-memory write port (one-cycle we pulse per word)
//   loaded               number of words written so far
//   cpu_run              image complete, sticky until reset
//   err                  load failed (oversized image or bad checksum), sticky until reset
module imem_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic [ADDR_W:0]   loaded,
  output logic              cpu_run,
  output logic              err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_RUN,
    S_ERR
  } state_t;
`endif

  // Largest legal image, widened so the 16-bit header count compares without overflow.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic [7:0]          n_lo_q, n_lo_d;    // count low byte, held until the high byte arrives
  logic [15:0]         n_q, n_d;          // word count N of the image
  logic [1:0]          bidx_q, bidx_d;    // byte position within the current word
  logic [23:0]         word_q, word_d;    // bytes 0..2 of the word being assembled
  logic [ADDR_W:0]     widx_q, widx_d;    // words written; doubles as next write address
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                cpu_run_q, cpu_run_d;
  logic                err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;    // running XOR of accepted data bytes
`endif

  logic                ready_state;
  logic                accept;
  logic [15:0]         hdr_n;
  logic [ADDR_W:0]     widx_inc;
  logic                last_word;

  always_comb begin
    ready_state = 1'b0;
    case (state_q)
      S_HDR0, S_HDR1, S_DATA: ready_state = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:                 ready_state = 1'b1;
`endif
      default:                ready_state = 1'b0;
    endcase
  end

  // Gated by reset so the stream sees no acceptance while the loader is being cleared.
  assign in_ready  = ready_state && !reset;
  assign accept    = in_valid && in_ready;
  assign hdr_n     = {in_byte, n_lo_q};
  assign widx_inc  = widx_q + {{ADDR_W{1'b0}}, 1'b1};
  assign last_word = (17'(widx_inc) == {1'b0, n_q});

  always_comb begin
    state_d   = state_q;
    n_lo_d    = n_lo_q;
    n_d       = n_q;
    bidx_d    = bidx_q;
    word_d    = word_q;
    widx_d    = widx_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cpu_run_d = cpu_run_q;
    err_d     = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      S_HDR0: begin
        if (accept) begin
          n_lo_d  = in_byte;
          state_d = S_HDR1;
        end
      end

      S_HDR1: begin
        if (accept) begin
          n_d = hdr_n;
          if (hdr_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            // Nothing to write, so the CPU can be released on the very next cycle.
            state_d   = S_RUN;
            cpu_run_d = 1'b1;
`endif
          end else if ({1'b0, hdr_n} > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ in_byte;
`endif
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: word_d[7:0]   = in_byte;
            2'd1: word_d[15:8]  = in_byte;
            2'd2: word_d[23:16] = in_byte;
            default: begin
              we_d    = 1'b1;
              waddr_d = widx_q[ADDR_W-1:0];
              wdata_d = {in_byte, word_q};
              widx_d  = widx_inc;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = S_CSUM;
`else
                // cpu_run is raised from RUN on the following edge, after the write lands.
                state_d = S_RUN;
`endif
              end
            end
          endcase
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          if (in_byte == csum_q) begin
            state_d   = S_RUN;
            cpu_run_d = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif

      S_RUN: begin
        cpu_run_d = 1'b1;
      end

      default: begin
        // ERR is terminal: hold everything, no writes.
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HDR0;
      n_lo_q    <= 8'd0;
      n_q       <= 16'd0;
      bidx_q    <= 2'd0;
      word_q    <= 24'd0;
      widx_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= 32'd0;
      cpu_run_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      n_lo_q    <= n_lo_d;
      n_q       <= n_d;
      bidx_q    <= bidx_d;
      word_q    <= word_d;
      widx_q    <= widx_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      cpu_run_q <= cpu_run_d;
      err_q     <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign we      = we_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  assign loaded  = widx_q;
  assign cpu_run = cpu_run_q;
  assign err     = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader with ADDR_W=6.
// Inputs are driven 1ns after the rising edge; outputs are sampled on the falling edge.
// A passive monitor records write pulses, accepted bytes and the cpu_run rise cycle.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'd0;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic [6:0]  loaded;
  logic        cpu_run;
  logic        err;

  imem_loader #(.ADDR_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_byte  (in_byte),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .loaded   (loaded),
    .cpu_run  (cpu_run),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];
  bit          run_seen = 1'b0;
  int          run_cyc = 0;
  int          acc_cnt = 0;

  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cnt++;
    if (we) begin
      wa_q.push_back(waddr);
      wd_q.push_back(wdata);
      wc_q.push_back(cyc);
    end
    if (cpu_run && !run_seen) begin
      run_seen = 1'b1;
      run_cyc  = cyc;
    end
  end

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
    run_seen = 1'b0;
    run_cyc  = 0;
    acc_cnt  = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
  endtask

  // Present one byte and hold it until accepted (bounded).
  task automatic send(input logic [7:0] b);
    bit acc;
    int t;
    acc = 1'b0;
    t   = 0;
    in_valid = 1'b1;
    in_byte  = b;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready got 0 required 1 for byte %h", b);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hold in_valid for n cycles regardless of in_ready.
  task automatic offer(input logic [7:0] b, input int n);
    in_valid = 1'b1;
    in_byte  = b;
    repeat (n) begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b required 0", we); end
    n_cmp++; if (waddr !== 6'd0) begin n_bad++; $display("FAIL rst_waddr: got %h required 0", waddr); end
    n_cmp++; if (wdata !== 32'd0) begin n_bad++; $display("FAIL rst_wdata: got %h required 0", wdata); end
    n_cmp++; if (loaded !== 7'd0) begin n_bad++; $display("FAIL rst_loaded: got %0d required 0", loaded); end
    n_cmp++; if (cpu_run !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_run: got %b required 0", cpu_run); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b required 0", err); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_in_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    clear_mon();
  endtask

  task automatic test_n2();
    logic [7:0] s [10];
    int c1, c2, exp_run;
    s = '{8'h02, 8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
    do_reset();
    c1 = 0;
    for (int i = 0; i < 10; i++) begin
      send(s[i]);
      if (i == 5) c1 = cyc;
    end
    c2 = cyc;
    @(negedge clk);
    n_cmp++; if (we !== 1'b1) begin n_bad++; $display("FAIL n2_we_last: got %b required 1", we); end
    n_cmp++; if (loaded !== 7'd2) begin n_bad++; $display("FAIL n2_loaded_at_we: got %0d required 2", loaded); end
    n_cmp++; if (cpu_run !== 1'b0) begin n_bad++; $display("FAIL n2_cpu_run_early: got %b required 0", cpu_run); end
    @(posedge clk); #1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h35);
    exp_run = cyc;
`else
    exp_run = c2 + 1;
`endif
    idle(3);
    @(negedge clk);
    n_cmp++; if (wa_q.size() !== 2) begin n_bad++; $display("FAIL n2_we_count: got %0d required 2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      n_cmp++; if (wa_q[0] !== 6'd0) begin n_bad++; $display("FAIL n2_waddr0: got %h required 0", wa_q[0]); end
      n_cmp++; if (wd_q[0] !== 32'h00000033) begin n_bad++; $display("FAIL n2_wdata0: got %h required 00000033", wd_q[0]); end
      n_cmp++; if (wa_q[1] !== 6'd1) begin n_bad++; $display("FAIL n2_waddr1: got %h required 1", wa_q[1]); end
      n_cmp++; if (wd_q[1] !== 32'h00100513) begin n_bad++; $display("FAIL n2_wdata1: got %h required 00100513", wd_q[1]); end
      n_cmp++; if (wc_q[0] !== c1) begin n_bad++; $display("FAIL n2_we0_cycle: got %0d required %0d", wc_q[0], c1); end
      n_cmp++; if (wc_q[1] !== c2) begin n_bad++; $display("FAIL n2_we1_cycle: got %0d required %0d", wc_q[1], c2); end
    end
    n_cmp++; if (run_cyc !== exp_run) begin n_bad++; $display("FAIL n2_run_cycle: got %0d required %0d", run_cyc, exp_run); end
    n_cmp++; if (cpu_run !== 1'b1) begin n_bad++; $display("FAIL n2_cpu_run: got %b required 1", cpu_run); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL n2_in_ready_run: got %b required 0", in_ready); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL n2_err: got %b required 0", err); end
    // Reset after a completed load must clear every output.
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (wdata !== 32'd0) begin n_bad++; $display("FAIL n2_rst_wdata: got %h required 0", wdata); end
    n_cmp++; if (waddr !== 6'd0) begin n_bad++; $display("FAIL n2_rst_waddr: got %h required 0", waddr); end
    n_cmp++; if (loaded !== 7'd0) begin n_bad++; $display("FAIL n2_rst_loaded: got %0d required 0", loaded); end
    n_cmp++; if (cpu_run !== 1'b0) begin n_bad++; $display("FAIL n2_rst_cpu_run: got %b required 0", cpu_run); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_n0();
    int c;
    do_reset();
    send(8'h00);
    send(8'h00);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    c = cyc;
    @(negedge clk);
    n_cmp++; if (cpu_run !== 1'b1) begin n_bad++; $display("FAIL n0_cpu_run: got %b required 1", cpu_run); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL n0_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    idle(3);
    @(negedge clk);
    n_cmp++; if (run_cyc !== c) begin n_bad++; $display("FAIL n0_run_cycle: got %0d required %0d", run_cyc, c); end
    n_cmp++; if (wa_q.size() !== 0) begin n_bad++; $display("FAIL n0_we_count: got %0d required 0", wa_q.size()); end
    n_cmp++; if (loaded !== 7'd0) begin n_bad++; $display("FAIL n0_loaded: got %0d required 0", loaded); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    do_reset();
    send(8'h41);
    send(8'h00);
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err: got %b required 1", err); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_in_ready: got %b required 0", in_ready); end
    @(posedge clk); #1;
    offer(8'hAA, 8);
    @(negedge clk);
    n_cmp++; if (wa_q.size() !== 0) begin n_bad++; $display("FAIL ovf_we_count: got %0d required 0", wa_q.size()); end
    n_cmp++; if (acc_cnt !== 2) begin n_bad++; $display("FAIL ovf_accepted: got %0d required 2", acc_cnt); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL ovf_err_sticky: got %b required 1", err); end
    n_cmp++; if (cpu_run !== 1'b0) begin n_bad++; $display("FAIL ovf_cpu_run: got %b required 0", cpu_run); end
    n_cmp++; if (loaded !== 7'd0) begin n_bad++; $display("FAIL ovf_loaded: got %0d required 0", loaded); end
    @(posedge clk); #1;
  endtask

  // N = 2^ADDR_W is the largest legal image; data byte k carries value k.
  task automatic test_max();
    do_reset();
    send(8'h40);
    send(8'h00);
    for (int i = 0; i < 256; i++) send(8'(i));
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00);
`endif
    idle(2);
    @(negedge clk);
    n_cmp++; if (loaded !== 7'd64) begin n_bad++; $display("FAIL max_loaded: got %0d required 64", loaded); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL max_err: got %b required 0", err); end
    n_cmp++; if (cpu_run !== 1'b1) begin n_bad++; $display("FAIL max_cpu_run: got %b required 1", cpu_run); end
    n_cmp++; if (wa_q.size() !== 64) begin n_bad++; $display("FAIL max_we_count: got %0d required 64", wa_q.size()); end
    if (wa_q.size() == 64) begin
      n_cmp++; if (wd_q[0] !== 32'h03020100) begin n_bad++; $display("FAIL max_wdata0: got %h required 03020100", wd_q[0]); end
      n_cmp++; if (wa_q[63] !== 6'd63) begin n_bad++; $display("FAIL max_waddr63: got %0d required 63", wa_q[63]); end
      n_cmp++; if (wd_q[63] !== 32'hFFFEFDFC) begin n_bad++; $display("FAIL max_wdata63: got %h required fffefdfc", wd_q[63]); end
      n_cmp++; if (wc_q[63] - wc_q[0] !== 252) begin n_bad++; $display("FAIL max_no_bubbles: got %0d required 252", wc_q[63] - wc_q[0]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_toggle();
    logic [7:0] s [6];
    int exp_acc;
    s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(s[i]);
      idle(1);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h22);
    exp_acc = 7;
`else
    exp_acc = 6;
`endif
    idle(2);
    @(negedge clk);
    n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL tog_we_count: got %0d required 1", wa_q.size()); end
    n_cmp++; if (wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL tog_wdata: got %h required deadbeef", wdata); end
    n_cmp++; if (waddr !== 6'd0) begin n_bad++; $display("FAIL tog_waddr: got %0d required 0", waddr); end
    n_cmp++; if (loaded !== 7'd1) begin n_bad++; $display("FAIL tog_loaded: got %0d required 1", loaded); end
    n_cmp++; if (cpu_run !== 1'b1) begin n_bad++; $display("FAIL tog_cpu_run: got %b required 1", cpu_run); end
    n_cmp++; if (acc_cnt !== exp_acc) begin n_bad++; $display("FAIL tog_accepted: got %0d required %0d", acc_cnt, exp_acc); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] s [5];
    logic [7:0] t [6];
    s = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    t = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    do_reset();
    for (int i = 0; i < 5; i++) send(s[i]);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL mid_we: got %b required 0", we); end
    n_cmp++; if (loaded !== 7'd0) begin n_bad++; $display("FAIL mid_loaded: got %0d required 0", loaded); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b required 0", err); end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_mon();
    for (int i = 0; i < 6; i++) send(t[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h08);
`endif
    idle(2);
    @(negedge clk);
    n_cmp++; if (wa_q.size() !== 1) begin n_bad++; $display("FAIL mid_we_count: got %0d required 1", wa_q.size()); end
    n_cmp++; if (waddr !== 6'd0) begin n_bad++; $display("FAIL mid_waddr: got %0d required 0", waddr); end
    n_cmp++; if (wdata !== 32'h12345678) begin n_bad++; $display("FAIL mid_wdata: got %h required 12345678", wdata); end
    n_cmp++; if (loaded !== 7'd1) begin n_bad++; $display("FAIL mid_loaded_after: got %0d required 1", loaded); end
    n_cmp++; if (cpu_run !== 1'b1) begin n_bad++; $display("FAIL mid_cpu_run: got %b required 1", cpu_run); end
    @(posedge clk); #1;
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] s [6];
    s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    do_reset();
    for (int i = 0; i < 6; i++) send(s[i]);
    send(8'h04);
    @(negedge clk);
    n_cmp++; if (cpu_run !== 1'b1) begin n_bad++; $display("FAIL csum_ok_cpu_run: got %b required 1", cpu_run); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL csum_ok_err: got %b required 0", err); end
    n_cmp++; if (wdata !== 32'h04030201) begin n_bad++; $display("FAIL csum_ok_wdata: got %h required 04030201", wdata); end
    @(posedge clk); #1;
    do_reset();
    for (int i = 0; i < 6; i++) send(s[i]);
    send(8'h05);
    idle(2);
    @(negedge clk);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL csum_bad_err: got %b required 1", err); end
    n_cmp++; if (cpu_run !== 1'b0) begin n_bad++; $display("FAIL csum_bad_cpu_run: got %b required 0", cpu_run); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_n2();
    test_n0();
    test_overflow();
    test_max();
    test_toggle();
    test_reset_mid();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
